// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: hazard sources from the pipeline in, per-register stall/flush
// controls and status out.
interface hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH    = 32
);
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_uses_rs1;
  logic                      id_uses_rs2;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_mem_read;
  logic                      ex_redirect;
  logic                      ex_mdu_start;
  logic                      mdu_done;
  logic                      dcache_wait;
  logic                      icache_wait;

  logic                      stall_pc;
  logic                      stall_if_id;
  logic                      stall_id_ex;
  logic                      stall_ex_mem;
  logic                      flush_if_id;
  logic                      flush_id_ex;
  logic                      flush_ex_mem;
  logic                      flush_mem_wb;
  logic                      mdu_busy;
  logic                      mdu_timeout;
  logic [COUNT_WIDTH-1:0]    stall_cycles;

  // Pipeline side: reports hazards, consumes stall/flush controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, ex_mdu_start, mdu_done, dcache_wait, icache_wait,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           mdu_busy, mdu_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_redirect, ex_mdu_start, mdu_done, dcache_wait, icache_wait,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
           mdu_busy, mdu_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline, with MDU sequencing FSM,
// MDU watchdog and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MDU_TIMEOUT    = 64,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned CNT_W = $clog2(MDU_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       mdu_cnt;
  logic                   mdu_timeout_q;
  logic [COUNT_WIDTH-1:0] stall_cnt;

  logic load_use;
  logic mdu_stall;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;

  always_comb begin
    load_use = hz.ex_mem_read && (hz.ex_rd != '0) &&
               ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
    // ex_mdu_start only matters in RUN; in MDU_BUSY the busy state alone stalls
    mdu_stall = !hz.mdu_done &&
                ((state == MDU_BUSY) || ((state == RUN) && hz.ex_mdu_start));
  end

  // Priority-encoded stall/flush; only the winning hazard drives anything
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    flush_mem_wb = 1'b0;
    if (!reset) begin
      if (hz.dcache_wait) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        flush_mem_wb = 1'b1;
      end else if (mdu_stall) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end else if (hz.ex_redirect) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
      end else if (load_use) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
      end else if (hz.icache_wait) begin
        stall_pc     = 1'b1;
        flush_if_id  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      mdu_cnt       <= '0;
      mdu_timeout_q <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      if (stall_pc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + COUNT_WIDTH'(1);
      case (state)
        RUN: begin
          if (hz.ex_mdu_start && !hz.mdu_done && !hz.dcache_wait) begin
            state   <= MDU_BUSY;
            mdu_cnt <= CNT_W'(1);
          end
        end
        MDU_BUSY: begin
          if (hz.mdu_done) begin
            state   <= RUN;
            mdu_cnt <= '0;
          end else if (mdu_cnt == CNT_LAST) begin
            mdu_timeout_q <= 1'b1;
            state         <= RUN;
            mdu_cnt       <= '0;
          end else begin
            mdu_cnt <= mdu_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= RUN;
          mdu_cnt <= '0;
        end
      endcase
    end
  end

  assign hz.stall_pc     = stall_pc;
  assign hz.stall_if_id  = stall_if_id;
  assign hz.stall_id_ex  = stall_id_ex;
  assign hz.stall_ex_mem = stall_ex_mem;
  assign hz.flush_if_id  = flush_if_id;
  assign hz.flush_id_ex  = flush_id_ex;
  assign hz.flush_ex_mem = flush_ex_mem;
  assign hz.flush_mem_wb = flush_mem_wb;
  assign hz.mdu_busy     = (state == MDU_BUSY);
  assign hz.mdu_timeout  = mdu_timeout_q;
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected outputs queued as stimulus is driven,
// compared on the falling edge.
module tb_hazard_ctrl;

  localparam int unsigned RAW = 5;
  localparam int unsigned TMO = 8;
  localparam int unsigned CW  = 4;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_WIDTH(RAW), .COUNT_WIDTH(CW)) bus ();

  hazard_ctrl #(
    .REG_ADDR_WIDTH(RAW),
    .MDU_TIMEOUT(TMO),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (bus.slave)
  );

  typedef struct {
    logic [RAW-1:0] rs1, rs2, rd;
    logic u1, u2, mrd, redir, mst, mdn, dw, iw;
  } stim_t;

  typedef struct {
    string          tag;
    logic [9:0]     flags;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int m_busy_len = 0;
  bit m_to       = 1'b0;
  int m_stalls   = 0;

  logic [9:0] dut_flags;
  assign dut_flags = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_mem,
                      bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem, bus.flush_mem_wb,
                      bus.mdu_busy, bus.mdu_timeout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rs1 = '0; s.rs2 = '0; s.rd = '0;
    s.u1 = 1'b0; s.u2 = 1'b0; s.mrd = 1'b0; s.redir = 1'b0;
    s.mst = 1'b0; s.mdn = 1'b0; s.dw = 1'b0; s.iw = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.id_rs1       = s.rs1;
    bus.id_rs2       = s.rs2;
    bus.id_uses_rs1  = s.u1;
    bus.id_uses_rs2  = s.u2;
    bus.ex_rd        = s.rd;
    bus.ex_mem_read  = s.mrd;
    bus.ex_redirect  = s.redir;
    bus.ex_mdu_start = s.mst;
    bus.mdu_done     = s.mdn;
    bus.dcache_wait  = s.dw;
    bus.icache_wait  = s.iw;
  endtask

  // Drive one cycle of stimulus just after the rising edge, queue the expectation,
  // then advance the model to the state after the next rising edge.
  task automatic step(input string tag, input stim_t s);
    exp_t       e;
    logic [7:0] so;
    bit         lu, ms;
    @(posedge clk);
    #1;
    apply(s);
    lu = s.mrd && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    ms = !s.mdn && ((m_busy_len != 0) || s.mst);
    //       {spc,sifid,sidex,sexmem, fifid,fidex,fexmem,fmemwb}
    if (s.dw)         so = 8'b1111_0001;
    else if (ms)      so = 8'b1110_0010;
    else if (s.redir) so = 8'b0000_1100;
    else if (lu)      so = 8'b1100_0100;
    else if (s.iw)    so = 8'b1000_1000;
    else              so = 8'b0000_0000;
    e.tag   = tag;
    e.flags = {so, (m_busy_len != 0), m_to};
    e.cnt   = CW'(m_stalls);
    sb.push_back(e);
    if (so[7] && m_stalls < SAT) m_stalls++;
    if (m_busy_len != 0) begin
      if (s.mdn) m_busy_len = 0;
      else if (m_busy_len == TMO - 1) begin
        m_to       = 1'b1;
        m_busy_len = 0;
      end else m_busy_len++;
    end else if (s.mst && !s.mdn && !s.dw) begin
      m_busy_len = 1;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "/flags"}, 32'(dut_flags), 32'(e.flags));
      check({e.tag, "/stall_cycles"}, 32'(bus.stall_cycles), 32'(e.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    apply(idle());
    #1;
    check("reset/flags", 32'(dut_flags), 32'd0);
    check("reset/stall_cycles", 32'(bus.stall_cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // T3: multi-cycle MDU op, done on the 5th cycle after start
    s = idle(); s.mst = 1'b1;
    for (int i = 0; i < 4; i++) step("t3_wait", s);
    s.mdn = 1'b1;
    step("t3_done", s);
    step("t3_idle", idle());
    @(negedge clk); #1;
    check("t3_stall_total", 32'(bus.stall_cycles), 32'd4);

    // T1: load x5 in EX, ID add x6,x5,x1
    s = idle(); s.mrd = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.rs2 = 5'd1; s.u1 = 1'b1; s.u2 = 1'b1;
    step("t1_loaduse", s);
    step("t1_after", idle());

    // Load-use through rs2
    s = idle(); s.mrd = 1'b1; s.rd = 5'd9; s.rs1 = 5'd2; s.rs2 = 5'd9; s.u1 = 1'b1; s.u2 = 1'b1;
    step("lu_rs2", s);

    // T2: x0 destination and unused rs2 never stall
    s = idle(); s.mrd = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
    step("t2_x0", s);
    s = idle(); s.mrd = 1'b1; s.rd = 5'd5; s.rs1 = 5'd3; s.rs2 = 5'd5; s.u1 = 1'b1;
    step("t2_no_rs2", s);
    s = idle(); s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    step("t2_not_load", s);

    // Single-cycle MDU op
    s = idle(); s.mst = 1'b1; s.mdn = 1'b1;
    step("mdu_1cyc", s);
    step("mdu_1cyc_after", idle());

    // T4: dcache_wait masks redirect and load-use; redirect wins once it drops
    s = idle(); s.dw = 1'b1; s.redir = 1'b1; s.mrd = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
    for (int i = 0; i < 3; i++) step("t4_dwait", s);
    s.dw = 1'b0;
    step("t4_redirect", s);
    step("t4_after", idle());

    // MDU start under dcache_wait must not enter MDU_BUSY
    s = idle(); s.mst = 1'b1; s.dw = 1'b1;
    step("mdu_dwait", s);
    s.dw = 1'b0; s.mdn = 1'b1;
    step("mdu_dwait_done", s);

    // Redirect beats load-use; icache_wait alone
    s = idle(); s.redir = 1'b1; s.iw = 1'b1; s.mrd = 1'b1; s.rd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1;
    step("redir_over_lu", s);
    s = idle(); s.iw = 1'b1;
    for (int i = 0; i < 12; i++) step("icache", s);
    @(negedge clk); #1;
    check("stall_saturated", 32'(bus.stall_cycles), 32'(SAT));

    // T5: watchdog with mdu_done never asserted
    s = idle(); s.mst = 1'b1;
    for (int i = 0; i < TMO; i++) step("t5_busy", s);
    step("t5_released", idle());
    @(negedge clk); #1;
    check("t5_timeout_sticky", 32'(bus.mdu_timeout), 32'd1);
    check("t5_run", 32'(bus.mdu_busy), 32'd0);

    // T6: asynchronous reset mid MDU_BUSY
    s = idle(); s.mst = 1'b1;
    for (int i = 0; i < 3; i++) step("t6_busy", s);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("t6_flags", 32'(dut_flags), 32'd0);
    check("t6_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    m_busy_len = 0; m_to = 1'b0; m_stalls = 0;
    apply(idle());
    @(negedge clk);
    reset = 1'b0;
    s = idle(); s.iw = 1'b1;
    step("t6_post_reset", s);
    step("t6_idle", idle());

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
